// File: rtl/fir_loader_pkg.sv
// Shared types and sizing helpers for the fir coefficient loader.
package fir_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } fir_ld_state_t;

  localparam int ORDER_DEF = 4;

  function automatic int cnt_width(input int order);
    return $clog2(order + 1);
  endfunction

  localparam int CNT_W = $clog2(ORDER_DEF + 1);

endpackage

// File: rtl/fir_loader_if.sv
// Host-facing bundle: coefficient config port, sample stream and fir-side outputs.
interface fir_loader_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ORDER  = 4
);
  localparam int AW = $clog2(ORDER);

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [COEF_W-1:0] cfg_wdata;
  logic              reload;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              load_sw;
  logic [COEF_W-1:0] coef_out;
  logic [DATA_W-1:0] fir_data;
  logic              busy;
  logic              cfg_drop;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, reload, s_valid, s_data,
    input  s_ready, load_sw, coef_out, fir_data, busy, cfg_drop
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, reload, s_valid, s_data,
    output s_ready, load_sw, coef_out, fir_data, busy, cfg_drop
  );

endinterface

// File: rtl/fir_coef_bank.sv
// ORDER x COEF_W coefficient register file: synchronous write, combinational read.
module fir_coef_bank #(
  parameter int ORDER  = 4,
  parameter int COEF_W = 8,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [COEF_W-1:0] wdata_i,
  output logic              drop_o,
  input  logic [AW-1:0]     raddr_i,
  output logic [COEF_W-1:0] rdata_o
);

  logic [COEF_W-1:0] mem_q [ORDER];
  logic              in_range;

  assign in_range = int'(waddr_i) < ORDER;
  assign drop_o   = we_i & ~in_range;
  assign rdata_o  = (int'(raddr_i) < ORDER) ? mem_q[raddr_i] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ORDER; i++) mem_q[i] <= '0;
    end else if (we_i && in_range) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/fir_loader.sv
// Sequencer that loads fir coefficients, flushes the delay line, then streams samples.
module fir_loader
  import fir_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ORDER  = ORDER_DEF,
  parameter int COEF_W = 8
) (
  input logic         clk,
  input logic         rst,
  fir_loader_if.slave bus
);

  localparam int AW = $clog2(ORDER);
  localparam int CW = cnt_width(ORDER);
  localparam logic [CW-1:0] LAST = CW'(ORDER - 1);

  fir_ld_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic [DATA_W-1:0] fd_q, fd_d;
  logic              drop_q, drop_d;

  logic              cfg_open;
  logic              reload_ok;
  logic              wr_en;
  logic              bank_drop;
  logic [AW-1:0]     rd_addr;
  logic [COEF_W-1:0] rd_data;

  assign cfg_open  = (state_q == IDLE) || (state_q == RUN);
  assign reload_ok = bus.reload && cfg_open;
  assign wr_en     = bus.cfg_we && cfg_open;

  fir_coef_bank #(
    .ORDER (ORDER),
    .COEF_W(COEF_W),
    .AW    (AW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en),
    .waddr_i(bus.cfg_addr),
    .wdata_i(bus.cfg_wdata),
    .drop_o (bank_drop),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RUN: begin
        if (bus.reload) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cnt_q == LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // coef_q shows the tap for the coming cycle; a same-cycle cfg write is
  // bypassed so a write issued together with reload is loaded immediately.
  always_comb begin
    rd_addr = '0;
    coef_d  = '0;
    if (state_q == LOAD) rd_addr = AW'(cnt_q + CW'(1));
    if (reload_ok || (state_q == LOAD && cnt_q != LAST)) begin
      coef_d = (wr_en && bus.cfg_addr == rd_addr) ? bus.cfg_wdata : rd_data;
    end

    fd_d = (state_q == RUN && bus.s_valid) ? bus.s_data : '0;

    drop_d = reload_ok ? 1'b0 : drop_q;
    if (bank_drop || (bus.cfg_we && !cfg_open)) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q <= '0;
      fd_q   <= '0;
      drop_q <= 1'b0;
    end else begin
      coef_q <= coef_d;
      fd_q   <= fd_d;
      drop_q <= drop_d;
    end
  end

  assign bus.load_sw  = (state_q == FLUSH) || (state_q == RUN);
  assign bus.s_ready  = (state_q == RUN);
  assign bus.busy     = (state_q == LOAD) || (state_q == FLUSH);
  assign bus.coef_out = coef_q;
  assign bus.fir_data = fd_q;
  assign bus.cfg_drop = drop_q;

endmodule

// File: tb/tb_fir_loader.sv
// Directed bench for fir_loader with a per-cycle expectation scoreboard.
module tb_fir_loader;

  typedef struct {
    int         cyc;
    string      name;
    logic       ld;
    logic [7:0] coef;
    logic [7:0] fd;
    logic       rdy;
    logic       bsy;
    logic       drp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_loader_if #(.DATA_W(8), .COEF_W(8), .ORDER(4)) bus ();

  fir_loader #(.DATA_W(8), .ORDER(4), .COEF_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Inputs set before a step are sampled at the next edge; the expectation
  // describes the outputs in the cycle following that edge.
  task automatic step(input string nm, input logic ld, input logic [7:0] cf,
                      input logic [7:0] fd, input logic rdy, input logic bsy,
                      input logic drp);
    exp_t e;
    e.cyc = cyc + 1; e.name = nm; e.ld = ld; e.coef = cf; e.fd = fd;
    e.rdy = rdy; e.bsy = bsy; e.drp = drp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      compared++;
      if (e.cyc < cyc) begin
        mismatched++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
      end else if (bus.load_sw !== e.ld || bus.coef_out !== e.coef || bus.fir_data !== e.fd ||
                   bus.s_ready !== e.rdy || bus.busy !== e.bsy || bus.cfg_drop !== e.drp) begin
        mismatched++;
        $display("FAIL %s cyc=%0d got ld=%b coef=%0d fd=%0d rdy=%b busy=%b drop=%b required ld=%b coef=%0d fd=%0d rdy=%b busy=%b drop=%b",
                 e.name, cyc, bus.load_sw, bus.coef_out, bus.fir_data, bus.s_ready, bus.busy,
                 bus.cfg_drop, e.ld, e.coef, e.fd, e.rdy, e.bsy, e.drp);
      end
    end
  end

  logic [7:0] bankv [4] = '{8'd124, 8'd214, 8'd57, 8'd33};
  logic [7:0] smp   [4] = '{8'd0, 8'd100, 8'd200, 8'd44};

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.reload = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;

    step("reset", 0, 0, 0, 0, 0, 0);
    step("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = 2'(i); bus.cfg_wdata = bankv[i];
      step("cfg_wr", 0, 0, 0, 0, 0, 0);
    end
    bus.cfg_we = 1'b0;

    bus.reload = 1'b1;
    step("load0", 0, 8'd124, 0, 0, 1, 0);
    bus.reload = 1'b0;
    step("load1", 0, 8'd214, 0, 0, 1, 0);
    step("load2", 0, 8'd57, 0, 0, 1, 0);
    step("load3", 0, 8'd33, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("flush", 1, 0, 0, 0, 1, 0);
    step("run_entry", 1, 0, 0, 1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1; bus.s_data = smp[i];
      step("run_smp", 1, 0, smp[i], 1, 0, 0);
    end
    bus.s_valid = 1'b0; bus.s_data = 8'd99;
    step("bubble", 1, 0, 0, 1, 0, 0);
    bus.s_valid = 1'b1; bus.s_data = 8'd77;
    step("run_smp", 1, 0, 8'd77, 1, 0, 0);

    bus.reload = 1'b1; bus.s_data = 8'd55;
    step("reload_run", 0, 8'd124, 8'd55, 0, 1, 0);
    bus.reload = 1'b0; bus.s_valid = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 8'd7;
    step("ld_drop", 0, 8'd214, 0, 0, 1, 1);
    bus.cfg_we = 1'b0;
    step("ld_drop", 0, 8'd57, 0, 0, 1, 1);
    step("ld_drop", 0, 8'd33, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("flush_drop", 1, 0, 0, 0, 1, 1);
    step("run_drop", 1, 0, 0, 1, 0, 1);

    bus.reload = 1'b1;
    step("replay0", 0, 8'd124, 0, 0, 1, 0);
    bus.reload = 1'b0;
    step("replay1", 0, 8'd214, 0, 0, 1, 0);
    step("replay2", 0, 8'd57, 0, 0, 1, 0);
    step("replay3", 0, 8'd33, 0, 0, 1, 0);
    step("flush_t5", 1, 0, 0, 0, 1, 0);
    bus.reload = 1'b1;
    step("flush_ign", 1, 0, 0, 0, 1, 0);
    bus.reload = 1'b0;
    step("flush_t7", 1, 0, 0, 0, 1, 0);
    step("flush_t8", 1, 0, 0, 0, 1, 0);
    step("run_t9", 1, 0, 0, 1, 0, 0);

    bus.reload = 1'b1;
    step("pre_rst0", 0, 8'd124, 0, 0, 1, 0);
    bus.reload = 1'b0;
    step("pre_rst1", 0, 8'd214, 0, 0, 1, 0);
    step("pre_rst2", 0, 8'd57, 0, 0, 1, 0);
    rst = 1'b1;
    step("mid_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("post_rst", 0, 0, 0, 0, 0, 0);
    bus.reload = 1'b1;
    step("clr_load", 0, 0, 0, 0, 1, 0);
    bus.reload = 1'b0;
    for (int i = 0; i < 3; i++) step("clr_load", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("flush", 1, 0, 0, 0, 1, 0);
    step("run_entry", 1, 0, 0, 1, 0, 0);

    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 8'd9; bus.reload = 1'b1;
    step("wr_reload0", 0, 8'd9, 0, 0, 1, 0);
    bus.cfg_we = 1'b0; bus.reload = 1'b0;
    for (int i = 0; i < 3; i++) step("wr_reload", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("flush", 1, 0, 0, 0, 1, 0);
    step("run_entry", 1, 0, 0, 1, 0, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_loader.md
# fir_loader

Host-side sequencer that drives the coefficient-load/run interface of the `fir` filter block. It holds a writable coefficient bank and, on command, serialises the coefficients into the filter while `load_sw` is low. It then flushes the filter delay line with zeros and switches the filter to run mode. In run mode it forwards a valid/ready sample stream to the filter's `data_in`, one sample per clock.

## Interface
Parameters:
- `DATA_W`, 8, sample width (matches fir `data_in`)
- `ORDER`, 4, number of filter taps / coefficients
- `COEF_W`, 8, coefficient width (matches fir `coff_in`)

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `cfg_we`  in  1  coefficient bank write strobe
- `cfg_addr`  in  $clog2(ORDER)  bank index
- `cfg_wdata`  in  COEF_W  coefficient value
- `reload`  in  1  single-cycle pulse; start a load sequence
- `s_valid`  in  1  input sample valid
- `s_data`  in  DATA_W  input sample
- `s_ready`  out  1  sample accepted when `s_valid & s_ready`
- `load_sw`  out  1  to fir `load_sw`; 0 = load, 1 = run
- `coef_out`  out  COEF_W  to fir `coff_in`
- `fir_data`  out  DATA_W  to fir `data_in`
- `busy`  out  1  high in LOAD or FLUSH
- `cfg_drop`  out  1  sticky flag: a cfg write was discarded

## Operation
- FSM states: IDLE, LOAD, FLUSH, RUN.
- Reset goes to IDLE. Reset clears the bank to 0 and sets every output to 0: `load_sw`, `coef_out`, `fir_data`, `s_ready`, `busy`, `cfg_drop`.
- IDLE: `load_sw`=0, `coef_out`=0.
  - The fir shifts zero coefficients while in IDLE; this is intended.
  - `reload` moves the FSM to LOAD.
- LOAD: lasts exactly ORDER cycles; tap counter k runs 0..ORDER-1.
  - `load_sw`=0, `coef_out`=bank[k], so bank[0] is presented first.
  - After the last tap the FSM moves to FLUSH.
- FLUSH: lasts exactly ORDER cycles.
  - `load_sw`=1, `fir_data`=0, `s_ready`=0.
  - Then the FSM moves to RUN.
- RUN: `load_sw`=1, `s_ready`=1.
  - On each accepted sample, `fir_data` is loaded with `s_data`.
  - A cycle with no valid sample loads `fir_data` with 0; bubbles become zero samples.
  - `reload` moves the FSM to LOAD.
- cfg writes:
  - Accepted in IDLE and RUN. A write in RUN changes the bank only; it takes effect at the next `reload`.
  - In LOAD/FLUSH the write is discarded and `cfg_drop` is set.
  - `cfg_addr` ≥ ORDER is discarded and sets `cfg_drop`.
  - `cfg_drop` is cleared by the next accepted `reload`, or by reset.
- `reload` in LOAD/FLUSH is ignored; the sequence is not restarted.
- Simultaneous `cfg_we` and `reload` in IDLE/RUN: the write lands first, and LOAD uses the new value.
- `rst` mid-sequence aborts immediately, returning to IDLE with the bank cleared.

## Timing
- All outputs are registered. `s_ready` is decoded from the registered state and has no combinational path from inputs.
- `reload` sampled at edge t gives:
  - cycles t+1..t+ORDER: `load_sw`=0, `coef_out` = bank[0..ORDER-1].
  - cycles t+ORDER+1..t+2·ORDER: FLUSH.
  - from cycle t+2·ORDER+1: RUN, with `s_ready`=1.
- Sample latency: a sample accepted at edge e is on `fir_data` for the cycle after e (1 cycle).
- `reload` accepted in RUN: `s_ready` drops and `load_sw`=0 in the next cycle. A sample presented in the same cycle as that `reload` is still accepted.
- `busy` is high for exactly 2·ORDER cycles per accepted `reload`.

## Structure
- Package `fir_loader_pkg`:
  - state enum `fir_ld_state_t` (IDLE, LOAD, FLUSH, RUN)
  - counter width constant `CNT_W = $clog2(ORDER+1)`
- Sub-module `fir_coef_bank`: ORDER×COEF_W register file.
  - Synchronous write, with address-range check that generates the drop strobe.
  - Combinational read port.
- The FSM, tap/flush counter and output registers live in the top module.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `busy`=0, `s_ready`=0.
- Write bank = {124, 214, 57, 33}, then `reload` → `coef_out` = 124, 214, 57, 33 on 4 consecutive cycles with `load_sw`=0. Then 4 cycles with `fir_data`=0 and `load_sw`=1. Then `s_ready`=1.
- RUN, `s_valid` held with `s_data` = 0, 100, 200, 44 (8-bit wrap) → `fir_data` shows the same sequence delayed by 1 cycle. Dropping `s_valid` for 1 cycle → `fir_data`=0 for that cycle.
- `cfg_we` (addr 1, data 7) during LOAD → `cfg_drop`=1 and the bank is unchanged. The next `reload` clears `cfg_drop` and replays 124, 214, 57, 33.
- `reload` during FLUSH → ignored; RUN is entered at the original cycle t+9.
- Assert `rst` in the 3rd LOAD cycle → the next cycle has all outputs 0 and state IDLE. A subsequent `reload` presents 0, 0, 0, 0.
